sipo_receiver_8bit: RTL

SIPO_RECEIVER_8BIT -- requirements
Module: sipo_receiver_8bit

---
 rtl/sipo_receiver_8bit_pkg.sv | 19 +
 rtl/sipo_out_stage.sv | 47 ++++
 rtl/sipo_receiver_8bit.sv | 69 ++++++
 3 files changed

// File: rtl/sipo_receiver_8bit_pkg.sv
// Shared types and constants for the 8-bit serial-in / parallel-out receiver.
package sipo_receiver_8bit_pkg;

  localparam int BYTE_W = 8;
  localparam int CNT_W  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // One shift step. The bit order decides which end of the register the new bit enters.
  function automatic logic [BYTE_W-1:0] shift_in(input logic [BYTE_W-1:0] sr,
                                                 input logic              b,
                                                 input logic              msb_first);
    return msb_first ? {sr[BYTE_W-2:0], b} : {b, sr[BYTE_W-1:1]};
  endfunction

endpackage

// File: rtl/sipo_out_stage.sv
// Output holding register: keeps the last completed byte until the consumer takes it.
// A byte that completes while an unconsumed one is held is dropped and flagged.
module sipo_out_stage
  import sipo_receiver_8bit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [BYTE_W-1:0] load_data,
  input  logic              data_ready,
  input  logic              overrun_clr,
  output logic [BYTE_W-1:0] data_out,
  output logic              data_valid,
  output logic              overrun
);

  logic accept;
  logic drop;

  // A held byte is consumed when valid meets ready; the slot is then free
  // for a byte completing on the very same edge.
  assign accept = data_valid & data_ready;
  assign drop   = load & data_valid & ~data_ready;

  // Holding register, valid flag and sticky overrun (set beats clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load && (!data_valid || data_ready)) begin
        data_out   <= load_data;
        data_valid <= 1'b1;
      end else if (accept) begin
        data_valid <= 1'b0;
      end

      if (drop) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sipo_receiver_8bit.sv
// 8-bit serial receiver: framing FSM and shift register, feeding a handshaked output stage.
module sipo_receiver_8bit
  import sipo_receiver_8bit_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sin_valid,
  input  logic              sin,
  input  logic              sin_start,
  input  logic              data_ready,
  input  logic              overrun_clr,
  output logic [BYTE_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              overrun
);

  state_t            state_reg;
  logic [BYTE_W-1:0] sr_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic [BYTE_W-1:0] sr_next;
  logic              byte_done;

  // A start bit always begins a new frame, so the 8th bit of a frame is
  // never itself a start bit; a restart simply discards the partial frame.
  assign sr_next   = shift_in(sr_reg, sin, MSB_FIRST);
  assign byte_done = sin_valid && !sin_start && (state_reg == SHIFT)
                     && (cnt_reg == CNT_W'(BYTE_W - 1));
  assign busy      = (state_reg == SHIFT);

  // Framing FSM with the shift register and bit counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      sr_reg    <= '0;
      cnt_reg   <= '0;
    end else if (sin_valid) begin
      if (sin_start) begin
        sr_reg    <= sr_next;
        cnt_reg   <= CNT_W'(1);
        state_reg <= SHIFT;
      end else if (state_reg == SHIFT) begin
        sr_reg <= sr_next;
        if (byte_done) begin
          cnt_reg   <= '0;
          state_reg <= IDLE;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  end

  sipo_out_stage u_out_stage (
    .clk         (clk),
    .reset       (reset),
    .load        (byte_done),
    .load_data   (sr_next),
    .data_ready  (data_ready),
    .overrun_clr (overrun_clr),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .overrun     (overrun)
  );

endmodule
